// File: rtl/ldata_axi_burst_writer_pkg.sv
// Shared definitions for the ldata AXI burst writer.
//   - AXI4 constants used on the write channels
//   - FSM state encoding of the burst writer
package pp_axi_pkg;

   localparam logic [2:0] AXSIZE_8B  = 3'd3;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_ADDR,
      ST_DATA,
      ST_RESP,
      ST_DONE
   } state_e;

endpackage

// File: rtl/ldata_axi_burst_writer_burst_len_calc.sv
// Burst length calculator (purely combinational).
// Ports:
//   addr_lo   in  [11:0]  low 12 bits of the 8-byte aligned burst start address
//   remaining in  [31:0]  words still to be written
//   len       out [31:0]  min(MAX_BURST, remaining, words left before the 4 KB boundary)
module burst_len_calc #(
   parameter int unsigned MAX_BURST = 16
) (
   input  logic [11:0] addr_lo,
   input  logic [31:0] remaining,
   output logic [31:0] len
);

   logic [12:0] bytes_to_4k;
   logic [31:0] words_to_4k;

   always_comb begin
      // addr_lo is 8-byte aligned, so the byte distance is an exact word multiple
      bytes_to_4k = 13'd4096 - {1'b0, addr_lo};
      words_to_4k = {19'd0, bytes_to_4k} >> 3;
      len = 32'(MAX_BURST);
      if (remaining < len) begin
         len = remaining;
      end
      if (words_to_4k < len) begin
         len = words_to_4k;
      end
   end

endmodule

// File: rtl/ldata_axi_burst_writer.sv
// AXI4 burst writer for the packed ldata word stream.
// Pops 64-bit words from a FWFT FIFO and writes them to memory as INCR bursts
// that never cross a 4 KB boundary, one outstanding burst at a time.
// Ports:
//   ap_clk/ap_rst            clock, asynchronous active-high reset
//   ap_start..ap_continue    ap_ctrl_chain block handshake
//   base_addr, num_words     job scalars, sampled when ap_start is accepted
//   ldata_*                  FWFT FIFO read side
//   m_axi_aw*/w*/b*          AXI4 write address, data and response channels
//   err                      sticky error, set by any non-OKAY write response
module ldata_axi_burst_writer
   import pp_axi_pkg::*;
#(
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned DATA_W    = 64
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  logic              ap_continue,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [31:0]       num_words,
   input  logic [63:0]       ldata_dout,
   input  logic              ldata_empty_n,
   output logic              ldata_read,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic [7:0]        m_axi_awlen,
   output logic [2:0]        m_axi_awsize,
   output logic [1:0]        m_axi_awburst,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   output logic [DATA_W-1:0] m_axi_wdata,
   output logic [7:0]        m_axi_wstrb,
   output logic              m_axi_wlast,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   input  logic [1:0]        m_axi_bresp,
   output logic              err
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         remaining_q, remaining_d;
   logic [31:0]         len_q, len_d;
   logic [7:0]          awlen_q, awlen_d;
   logic [31:0]         beat_cnt_q, beat_cnt_d;
   logic                err_q, err_d;
   logic [31:0]         calc_len;
   logic                wvalid_c;

   burst_len_calc #(
      .MAX_BURST (MAX_BURST)
   ) u_len_calc (
      .addr_lo   (addr_q[11:0]),
      .remaining (remaining_q),
      .len       (calc_len)
   );

   // State and datapath registers
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         len_q       <= '0;
         awlen_q     <= '0;
         beat_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         len_q       <= len_d;
         awlen_q     <= awlen_d;
         beat_cnt_q  <= beat_cnt_d;
         err_q       <= err_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      len_d       = len_q;
      awlen_d     = awlen_q;
      beat_cnt_d  = beat_cnt_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (ap_start) begin
               addr_d      = base_addr & ~ADDR_W'(7);
               remaining_d = num_words;
               err_d       = 1'b0;
               state_d     = (num_words == 32'd0) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            len_d      = calc_len;
            awlen_d    = 8'(calc_len - 32'd1);
            beat_cnt_d = calc_len;
            state_d    = ST_ADDR;
         end
         ST_ADDR: begin
            if (m_axi_awready) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (ldata_empty_n && m_axi_wready) begin
               beat_cnt_d = beat_cnt_q - 32'd1;
               if (beat_cnt_q == 32'd1) begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (m_axi_bvalid) begin
               if (m_axi_bresp != RESP_OKAY) begin
                  err_d = 1'b1;
               end
               addr_d      = addr_q + (ADDR_W'(len_q) << 3);
               remaining_d = remaining_q - len_q;
               state_d     = (remaining_q != len_q) ? ST_CALC : ST_DONE;
            end
         end
         ST_DONE: begin
            if (ap_continue) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decode from the registered state only, so an asynchronous reset
   // drops every valid and the FIFO pop in the same cycle.
   always_comb begin
      ap_idle       = (state_q == ST_IDLE) && !ap_start;
      ap_ready      = (state_q == ST_IDLE) && ap_start;
      ap_done       = (state_q == ST_DONE);
      m_axi_awvalid = (state_q == ST_ADDR);
      wvalid_c      = (state_q == ST_DATA) && ldata_empty_n;
      m_axi_wvalid  = wvalid_c;
      ldata_read    = wvalid_c && m_axi_wready;
      m_axi_wlast   = (state_q == ST_DATA) && (beat_cnt_q == 32'd1);
      m_axi_bready  = (state_q == ST_RESP);
   end

   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = awlen_q;
   assign m_axi_awsize  = AXSIZE_8B;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_wdata   = ldata_dout;
   assign m_axi_wstrb   = 8'hFF;
   assign err           = err_q;

endmodule

// File: tb/tb_ldata_axi_burst_writer.sv
module tb_ldata_axi_burst_writer;

   logic        clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        ap_start = 1'b0;
   logic        ap_done, ap_idle, ap_ready;
   logic        ap_continue = 1'b0;
   logic [63:0] base_addr = '0;
   logic [31:0] num_words = '0;
   logic [63:0] ldata_dout = '0;
   logic        ldata_empty_n = 1'b0;
   logic        ldata_read;
   logic        m_axi_awvalid;
   logic        m_axi_awready = 1'b1;
   logic [63:0] m_axi_awaddr;
   logic [7:0]  m_axi_awlen;
   logic [2:0]  m_axi_awsize;
   logic [1:0]  m_axi_awburst;
   logic        m_axi_wvalid;
   logic        m_axi_wready = 1'b1;
   logic [63:0] m_axi_wdata;
   logic [7:0]  m_axi_wstrb;
   logic        m_axi_wlast;
   logic        m_axi_bvalid = 1'b0;
   logic        m_axi_bready;
   logic [1:0]  m_axi_bresp = 2'b00;
   logic        err;

   int errors = 0;
   int checks = 0;

   // FIFO contents and scoreboard queues
   logic [63:0] fifo_q[$];
   logic [63:0] exp_wdata[$];
   logic        exp_wlast[$];
   logic [63:0] exp_aw_addr[$];
   logic [7:0]  exp_aw_len[$];
   logic [1:0]  bresp_plan[$];

   int read_cnt = 0;
   int aw_cnt = 0;
   bit rand_ready = 0;
   bit fifo_toggle = 0;
   bit fifo_gate = 1;
   bit pend_pop = 0;
   bit pend_b = 0;
   bit b_done = 0;

   always #5 clk = ~clk;

   ldata_axi_burst_writer #(
      .MAX_BURST (16),
      .ADDR_W    (64),
      .DATA_W    (64)
   ) dut (
      .ap_clk        (clk),
      .ap_rst        (ap_rst),
      .ap_start      (ap_start),
      .ap_done       (ap_done),
      .ap_idle       (ap_idle),
      .ap_ready      (ap_ready),
      .ap_continue   (ap_continue),
      .base_addr     (base_addr),
      .num_words     (num_words),
      .ldata_dout    (ldata_dout),
      .ldata_empty_n (ldata_empty_n),
      .ldata_read    (ldata_read),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awlen   (m_axi_awlen),
      .m_axi_awsize  (m_axi_awsize),
      .m_axi_awburst (m_axi_awburst),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wlast   (m_axi_wlast),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_bresp   (m_axi_bresp),
      .err           (err)
   );

   // FIFO + AXI slave model with scoreboard. Inputs change on the falling edge;
   // handshakes are observed 1 time unit later, i.e. with the values the next
   // rising edge will commit, and their effects are applied on the next falling edge.
   initial begin
      logic [63:0] ea;
      logic [7:0]  el;
      logic [63:0] ed;
      logic        ew;
      forever begin
         @(negedge clk);
         if (ap_rst) begin
            pend_pop = 0; pend_b = 0; b_done = 0;
            m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
         end else begin
            if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (b_done) begin m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; end
            if (pend_b) begin
               m_axi_bvalid = 1'b1;
               m_axi_bresp  = (bresp_plan.size() > 0) ? bresp_plan.pop_front() : 2'b00;
            end
            pend_pop = 0; pend_b = 0; b_done = 0;
         end
         m_axi_awready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axi_wready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         fifo_gate     = fifo_toggle ? ~fifo_gate : 1'b1;
         ldata_empty_n = fifo_gate && (fifo_q.size() > 0);
         ldata_dout    = (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
         #1;
         if (!ap_rst) begin
            if (m_axi_awvalid && m_axi_awready) begin
               aw_cnt++;
               checks++;
               if (exp_aw_addr.size() == 0) begin
                  errors++;
                  $display("FAIL aw_unexpected: awaddr=%h awlen=%0d, required no AW", m_axi_awaddr, m_axi_awlen);
               end else begin
                  ea = exp_aw_addr.pop_front();
                  el = exp_aw_len.pop_front();
                  checks++;
                  if (m_axi_awaddr !== ea) begin
                     errors++;
                     $display("FAIL awaddr: got %h required %h", m_axi_awaddr, ea);
                  end
                  checks++;
                  if (m_axi_awlen !== el) begin
                     errors++;
                     $display("FAIL awlen: got %0d required %0d", m_axi_awlen, el);
                  end
                  checks++;
                  if (m_axi_awsize !== 3'd3 || m_axi_awburst !== 2'b01) begin
                     errors++;
                     $display("FAIL awsize_burst: got %0d/%b required 3/01", m_axi_awsize, m_axi_awburst);
                  end
               end
            end
            checks++;
            if (ldata_read !== (m_axi_wvalid && m_axi_wready)) begin
               errors++;
               $display("FAIL ldata_read: got %b required %b", ldata_read, m_axi_wvalid && m_axi_wready);
            end
            if (m_axi_wvalid) begin
               checks++;
               if (ldata_empty_n !== 1'b1) begin
                  errors++;
                  $display("FAIL wvalid_when_empty: wvalid=1 required 0");
               end
            end
            if (m_axi_wvalid && m_axi_wready) begin
               read_cnt++;
               pend_pop = 1;
               checks++;
               if (exp_wdata.size() == 0) begin
                  errors++;
                  $display("FAIL w_unexpected: wdata=%h, required no beat", m_axi_wdata);
               end else begin
                  ed = exp_wdata.pop_front();
                  ew = exp_wlast.pop_front();
                  checks++;
                  if (m_axi_wdata !== ed) begin
                     errors++;
                     $display("FAIL wdata: got %h required %h", m_axi_wdata, ed);
                  end
                  checks++;
                  if (m_axi_wlast !== ew) begin
                     errors++;
                     $display("FAIL wlast: got %b required %b", m_axi_wlast, ew);
                  end
                  checks++;
                  if (m_axi_wstrb !== 8'hFF) begin
                     errors++;
                     $display("FAIL wstrb: got %h required ff", m_axi_wstrb);
                  end
               end
               if (m_axi_wlast) pend_b = 1;
            end
            if (m_axi_bvalid && m_axi_bready) b_done = 1;
         end
      end
   end

   // Stimulus helpers (no comparisons inside)
   task automatic load_fifo(input int n, input bit expect_beats);
      logic [63:0] w;
      for (int i = 0; i < n; i++) begin
         w = {$urandom, $urandom};
         fifo_q.push_back(w);
         if (expect_beats) exp_wdata.push_back(w);
      end
   endtask

   task automatic push_burst(input logic [63:0] addr, input int beats);
      exp_aw_addr.push_back(addr);
      exp_aw_len.push_back(8'(beats - 1));
      for (int i = 1; i <= beats; i++) exp_wlast.push_back(i == beats);
   endtask

   task automatic start_job(input logic [63:0] b, input logic [31:0] n, output logic rdy);
      @(negedge clk);
      base_addr = b;
      num_words = n;
      ap_start  = 1'b1;
      #2;
      rdy = ap_ready;
      @(negedge clk);
      ap_start = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, output bit ok);
      ok = 0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         #2;
         if (ap_done === 1'b1) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic do_continue();
      @(negedge clk);
      ap_continue = 1'b1;
      @(negedge clk);
      ap_continue = 1'b0;
      #2;
   endtask

   task automatic test_reset();
      ap_rst = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      checks++;
      if ({ap_done, ap_ready, ldata_read, m_axi_awvalid, m_axi_wvalid, m_axi_bready, err} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 0000000",
                  {ap_done, ap_ready, ldata_read, m_axi_awvalid, m_axi_wvalid, m_axi_bready, err});
      end
      checks++;
      if (m_axi_awaddr !== 64'd0 || m_axi_awlen !== 8'd0) begin
         errors++;
         $display("FAIL reset_addr_len: got %h/%0d required 0/0", m_axi_awaddr, m_axi_awlen);
      end
      @(negedge clk);
      ap_rst = 1'b0;
      @(negedge clk);
      #2;
      checks++;
      if (ap_idle !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle: got %b required 1", ap_idle);
      end
   endtask

   task automatic test_multi_burst();
      logic rdy;
      bit ok;
      int r0, a0;
      r0 = read_cnt; a0 = aw_cnt;
      load_fifo(40, 1);
      push_burst(64'h1000, 16);
      push_burst(64'h1080, 16);
      push_burst(64'h1100, 8);
      start_job(64'h1000, 32'd40, rdy);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL multi_ready: got %b required 1", rdy); end
      wait_done(400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL multi_done_timeout: got no ap_done required ap_done"); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL multi_err: got %b required 0", err); end
      checks++;
      if (read_cnt - r0 != 40) begin errors++; $display("FAIL multi_pops: got %0d required 40", read_cnt - r0); end
      checks++;
      if (aw_cnt - a0 != 3) begin errors++; $display("FAIL multi_bursts: got %0d required 3", aw_cnt - a0); end
      checks++;
      if (exp_aw_addr.size() != 0 || exp_wdata.size() != 0) begin
         errors++;
         $display("FAIL multi_leftover: got %0d AW / %0d W outstanding required 0/0", exp_aw_addr.size(), exp_wdata.size());
      end
      do_continue();
      checks++;
      if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
         errors++;
         $display("FAIL multi_continue: idle/done got %b/%b required 1/0", ap_idle, ap_done);
      end
   endtask

   task automatic test_4k_split();
      logic rdy;
      bit ok;
      int r0, a0;
      r0 = read_cnt; a0 = aw_cnt;
      load_fifo(10, 1);
      push_burst(64'h0FE8, 3);
      push_burst(64'h1000, 7);
      // low address bits are dropped by the DUT
      start_job(64'h0FED, 32'd10, rdy);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL split_ready: got %b required 1", rdy); end
      wait_done(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL split_done_timeout: got no ap_done required ap_done"); end
      checks++;
      if (read_cnt - r0 != 10 || aw_cnt - a0 != 2) begin
         errors++;
         $display("FAIL split_counts: got pops=%0d aw=%0d required 10/2", read_cnt - r0, aw_cnt - a0);
      end
      do_continue();
   endtask

   task automatic test_zero_words();
      logic rdy;
      int r0, a0;
      r0 = read_cnt; a0 = aw_cnt;
      load_fifo(2, 0);
      start_job(64'h7000, 32'd0, rdy);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b required 1", rdy); end
      #2;
      checks++;
      if (ap_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b required 1", ap_done); end
      do_continue();
      checks++;
      if (read_cnt != r0 || aw_cnt != a0 || fifo_q.size() != 2) begin
         errors++;
         $display("FAIL zero_activity: got pops=%0d aw=%0d fifo=%0d required 0/0/2",
                  read_cnt - r0, aw_cnt - a0, fifo_q.size());
      end
      fifo_q.delete();
      @(negedge clk);
   endtask

   task automatic test_throttled();
      logic rdy;
      bit ok;
      int r0;
      r0 = read_cnt;
      rand_ready  = 1;
      fifo_toggle = 1;
      load_fifo(20, 1);
      push_burst(64'h2000, 16);
      push_burst(64'h2080, 4);
      start_job(64'h2000, 32'd20, rdy);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL throttle_ready: got %b required 1", rdy); end
      wait_done(2000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL throttle_done_timeout: got no ap_done required ap_done"); end
      checks++;
      if (read_cnt - r0 != 20) begin errors++; $display("FAIL throttle_pops: got %0d required 20", read_cnt - r0); end
      checks++;
      if (exp_wlast.size() != 0) begin errors++; $display("FAIL throttle_leftover: got %0d beats outstanding required 0", exp_wlast.size()); end
      rand_ready  = 0;
      fifo_toggle = 0;
      do_continue();
   endtask

   task automatic test_bresp_err();
      logic rdy;
      bit ok;
      bresp_plan.push_back(2'b00);
      bresp_plan.push_back(2'b10);
      load_fifo(24, 1);
      push_burst(64'h3000, 16);
      push_burst(64'h3080, 8);
      start_job(64'h3000, 32'd24, rdy);
      wait_done(300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL err_done_timeout: got no ap_done required ap_done"); end
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b required 1", err); end
      do_continue();
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err); end
      start_job(64'h3000, 32'd0, rdy);
      #2;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", err); end
      do_continue();
   endtask

   task automatic test_done_hold();
      logic rdy;
      int a0;
      a0 = aw_cnt;
      start_job(64'h6000, 32'd0, rdy);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         ap_start  = 1'b1;
         num_words = 32'd8;
         #2;
         checks++;
         if (ap_done !== 1'b1 || ap_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_done: cycle %0d done/ready got %b/%b required 1/0", i, ap_done, ap_ready);
         end
      end
      @(negedge clk);
      ap_start = 1'b0;
      do_continue();
      checks++;
      if (ap_idle !== 1'b1 || aw_cnt != a0) begin
         errors++;
         $display("FAIL hold_release: idle=%b aw=%0d required 1/0", ap_idle, aw_cnt - a0);
      end
   endtask

   task automatic test_reset_mid_data();
      logic rdy;
      bit ok;
      int r0;
      r0 = read_cnt;
      load_fifo(16, 1);
      push_burst(64'h4000, 16);
      start_job(64'h4000, 32'd16, rdy);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #2;
         if (read_cnt - r0 >= 3) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_data_timeout: got %0d beats required 3", read_cnt - r0); end
      @(negedge clk);
      #3;
      ap_rst = 1'b1;
      #1;
      checks++;
      if ({ap_done, ap_ready, ldata_read, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, err} !== 8'b0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got %b required 00000000",
                  {ap_done, ap_ready, ldata_read, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, err});
      end
      checks++;
      if (m_axi_awaddr !== 64'd0 || m_axi_awlen !== 8'd0) begin
         errors++;
         $display("FAIL rst_mid_addr: got %h/%0d required 0/0", m_axi_awaddr, m_axi_awlen);
      end
      @(negedge clk);
      fifo_q.delete(); exp_wdata.delete(); exp_wlast.delete();
      exp_aw_addr.delete(); exp_aw_len.delete(); bresp_plan.delete();
      @(negedge clk);
      ap_rst = 1'b0;
      // short job to confirm recovery
      load_fifo(4, 1);
      push_burst(64'h5000, 4);
      start_job(64'h5000, 32'd4, rdy);
      wait_done(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_recover_timeout: got no ap_done required ap_done"); end
      do_continue();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_multi_burst();
      test_4k_split();
      test_zero_words();
      test_throttled();
      test_bresp_err();
      test_done_hold();
      test_reset_mid_data();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
